// File: rtl/key_expand_seq.sv
// key_expand_seq
//   Iterative AES key schedule for AES-128/192/256, with the key length chosen at
//   start time. Each cycle one 32-bit schedule word is produced through a single
//   SubWord unit made of four S-box lookups. All words are kept in a word store,
//   and a registered port serves 128-bit round keys from it to the cipher datapath.
// Ports
//   clk, rst    clock and synchronous active-high reset
//   start       expansion request, looked at only while idle
//   key_len     00=AES-128, 01=AES-192, 10=AES-256, 11=reserved (rejected)
//   key_in      cipher key, left-justified (w[0] = key_in[255:224])
//   busy        expansion in progress
//   done        one-cycle pulse when the whole schedule is stored
//   err         one-cycle pulse when a start request is rejected
//   num_rounds  Nr of the last accepted key
//   rk_addr     round-key index to read
//   rk_data     registered round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}
//   rk_valid    stored schedule complete and readable

module sbox_lut (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    // Entry 0x00 sits in the top byte, so entry k is the byte at bit offset 8*(255-k).
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_byte = SBOX_TABLE[{~in_byte, 3'b000} +: 8];
endmodule

module key_expand_seq #(
    parameter int MAX_KEY_BITS = 256,
    parameter int MAX_WORDS    = 60
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [3:0]   num_rounds,
    input  logic [3:0]   rk_addr,
    output logic [127:0] rk_data,
    output logic         rk_valid
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t         state_r, state_s;
    logic           busy_r, done_r, err_r, rk_valid_r;
    logic [3:0]     num_rounds_r, nk_r;
    logic [5:0]     idx_r, last_idx_r;
    logic [2:0]     mod_r;
    logic [7:0]     rcon_r;
    logic [255:0]   win_r;
    logic [127:0]   rk_data_r;
    logic [31:0]    store_r [0:MAX_WORDS-1];

    logic [3:0]     dec_nk_s, dec_nr_s;
    logic           dec_ok_s, accept_s, reject_s, last_s;
    logic [5:0]     dec_last_s, rd_base_s;
    logic [31:0]    prev_s, back_s, sub_in_s, sub_out_s, temp_s, new_word_s;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Key length decode: Nk, Nr and whether this build supports the length.
    always_comb begin
        dec_nk_s = 4'd4;
        dec_nr_s = 4'd10;
        dec_ok_s = 1'b1;
        case (key_len)
            2'b00:   begin dec_nk_s = 4'd4; dec_nr_s = 4'd10; end
            2'b01:   begin dec_nk_s = 4'd6; dec_nr_s = 4'd12; end
            2'b10:   begin dec_nk_s = 4'd8; dec_nr_s = 4'd14; end
            default: dec_ok_s = 1'b0;
        endcase
        if ((int'(dec_nk_s) * 32) > MAX_KEY_BITS) begin
            dec_ok_s = 1'b0;
        end else begin
            dec_ok_s = dec_ok_s;
        end
    end

    assign dec_last_s = {dec_nr_s, 2'b00} + 6'd3;
    assign accept_s   = (state_r == ST_IDLE) && start && dec_ok_s;
    assign reject_s   = (state_r == ST_IDLE) && start && !dec_ok_s;
    assign last_s     = (state_r == ST_EXPAND) && (idx_r == last_idx_r);

    // Window taps: newest word w[i-1] sits in the low 32 bits, w[i-Nk] is Nk-1 words up.
    always_comb begin
        prev_s = win_r[31:0];
        case (nk_r)
            4'd6:    back_s = win_r[191:160];
            4'd8:    back_s = win_r[255:224];
            default: back_s = win_r[127:96];
        endcase
        if (mod_r == 3'd0) begin
            sub_in_s = {prev_s[23:0], prev_s[31:24]};
        end else begin
            sub_in_s = prev_s;
        end
    end

    sbox_lut u_sbox0 (.in_byte(sub_in_s[31:24]), .out_byte(sub_out_s[31:24]));
    sbox_lut u_sbox1 (.in_byte(sub_in_s[23:16]), .out_byte(sub_out_s[23:16]));
    sbox_lut u_sbox2 (.in_byte(sub_in_s[15:8]),  .out_byte(sub_out_s[15:8]));
    sbox_lut u_sbox3 (.in_byte(sub_in_s[7:0]),   .out_byte(sub_out_s[7:0]));

    // Schedule word: rotate/sub/rcon at Nk boundaries, extra SubWord mid-block for 256-bit keys.
    always_comb begin
        if (mod_r == 3'd0) begin
            temp_s = sub_out_s ^ {rcon_r, 24'h000000};
        end else if ((nk_r == 4'd8) && (mod_r == 3'd4)) begin
            temp_s = sub_out_s;
        end else begin
            temp_s = prev_s;
        end
        new_word_s = back_s ^ temp_s;
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_s = ST_EXPAND;
                else          state_s = ST_IDLE;
            end
            ST_EXPAND: begin
                if (last_s) state_s = ST_DONE;
                else        state_s = ST_EXPAND;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_s;
    end

    // Control, status and datapath registers (word store excluded).
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            rk_valid_r   <= 1'b0;
            num_rounds_r <= 4'd10;
            nk_r         <= 4'd4;
            idx_r        <= 6'd0;
            last_idx_r   <= 6'd43;
            mod_r        <= 3'd0;
            rcon_r       <= 8'h01;
            win_r        <= 256'h0;
        end else begin
            busy_r <= accept_s || ((state_r == ST_EXPAND) && !last_s);
            done_r <= last_s;
            err_r  <= reject_s;
            if (accept_s) begin
                rk_valid_r   <= 1'b0;
                num_rounds_r <= dec_nr_s;
                nk_r         <= dec_nk_s;
                idx_r        <= {2'b00, dec_nk_s};
                last_idx_r   <= dec_last_s;
                mod_r        <= 3'd0;
                rcon_r       <= 8'h01;
                // Right-justify the Nk key words so w[Nk-1] is the newest window entry.
                case (dec_nk_s)
                    4'd6:    win_r <= {64'h0, key_in[255:64]};
                    4'd8:    win_r <= key_in;
                    default: win_r <= {128'h0, key_in[255:128]};
                endcase
            end else if (state_r == ST_EXPAND) begin
                rk_valid_r <= last_s;
                idx_r      <= idx_r + 6'd1;
                if ({1'b0, mod_r} == (nk_r - 4'd1)) mod_r <= 3'd0;
                else                                 mod_r <= mod_r + 3'd1;
                if (mod_r == 3'd0) rcon_r <= xtime(rcon_r);
                else               rcon_r <= rcon_r;
                win_r <= {win_r[223:0], new_word_s};
            end else begin
                rk_valid_r <= rk_valid_r;
            end
        end
    end

    // Word store: key words on acceptance, one schedule word per expansion cycle; never cleared.
    always_ff @(posedge clk) begin
        if (!rst && accept_s) begin
            for (int j = 0; j < 8; j++) begin
                if (j < int'(dec_nk_s)) store_r[j] <= key_in[255-32*j -: 32];
            end
        end else if (!rst && (state_r == ST_EXPAND)) begin
            store_r[idx_r] <= new_word_s;
        end
    end

    assign rd_base_s = {rk_addr, 2'b00};

    // Registered round-key read; indices beyond Nr read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rk_data_r <= 128'h0;
        end else if (rk_addr > num_rounds_r) begin
            rk_data_r <= 128'h0;
        end else begin
            rk_data_r <= {store_r[rd_base_s], store_r[rd_base_s + 6'd1],
                          store_r[rd_base_s + 6'd2], store_r[rd_base_s + 6'd3]};
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;
    assign rk_valid   = rk_valid_r;
    assign num_rounds = num_rounds_r;
    assign rk_data    = rk_data_r;
endmodule

// File: tb/tb_key_expand_seq.sv
// tb_key_expand_seq
//   Directed bench for key_expand_seq: FIPS-197 key expansion vectors for all
//   three key lengths, stray start pulses, reset mid-expansion and reserved key_len.
// Ports: none (top-level bench).

module tb_key_expand_seq;
    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic         busy, done, err, rk_valid;
    logic [3:0]   num_rounds;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0]   kl;
        logic [255:0] key;
        logic [3:0]   nr;
        int           lat;
        bit           glitch;
    } key_vec_t;

    typedef struct {
        int           kidx;
        logic [3:0]   addr;
        logic [127:0] exp_rk;
    } rd_vec_t;

    key_vec_t kv [3];
    rd_vec_t  rv [13];

    key_expand_seq dut (
        .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key_in(key_in),
        .busy(busy), .done(done), .err(err), .num_rounds(num_rounds),
        .rk_addr(rk_addr), .rk_data(rk_data), .rk_valid(rk_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch expansion of kv[k]; check busy/rk_valid every cycle, latency, done pulse.
    task automatic run_expand(input int k);
        int cnt;
        int busy_bad;
        int valid_bad;
        cnt = 0; busy_bad = 0; valid_bad = 0;
        key_len = kv[k].kl;
        key_in  = kv[k].key;
        start   = 1'b1;
        tick();                     // edge E0
        start = 1'b0;
        while (!done && cnt < 100) begin
            if (!busy)    busy_bad++;
            if (rk_valid) valid_bad++;
            start = kv[k].glitch && (cnt == 4 || cnt == 38);
            tick();
            cnt++;
        end
        start = 1'b0;
        chk($sformatf("latency_k%0d", k), 128'(cnt), 128'(kv[k].lat));
        chk($sformatf("busy_during_k%0d", k), 128'(busy_bad), 128'd0);
        chk($sformatf("valid_during_k%0d", k), 128'(valid_bad), 128'd0);
        chk($sformatf("done_state_k%0d", k), {125'd0, done, busy, rk_valid}, {125'd0, 3'b101});
        chk($sformatf("num_rounds_k%0d", k), 128'(num_rounds), 128'(kv[k].nr));
        tick();
        chk($sformatf("after_done_k%0d", k), {125'd0, done, busy, rk_valid}, {125'd0, 3'b001});
    endtask

    // Apply every read vector belonging to key k.
    task automatic read_checks(input int k);
        for (int r = 0; r < 13; r++) begin
            if (rv[r].kidx == k) begin
                rk_addr = rv[r].addr;
                tick();
                chk($sformatf("rk_k%0d_a%0d", k, rv[r].addr), rk_data, rv[r].exp_rk);
            end
        end
    endtask

    initial begin
        kv[0] = '{2'b00, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4'd10, 40, 1'b1};
        kv[1] = '{2'b01, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 4'd12, 46, 1'b0};
        kv[2] = '{2'b10, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                  4'd14, 52, 1'b0};

        rv[0]  = '{0, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        rv[1]  = '{0, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        rv[2]  = '{0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        rv[3]  = '{0, 4'd11, 128'h0};
        rv[4]  = '{0, 4'd15, 128'h0};
        rv[5]  = '{1, 4'd1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5};
        rv[6]  = '{1, 4'd12, 128'he98ba06f448c773c8ecc720401002202};
        rv[7]  = '{1, 4'd13, 128'h0};
        rv[8]  = '{2, 4'd0,  128'h603deb1015ca71be2b73aef0857d7781};
        rv[9]  = '{2, 4'd2,  128'h9ba354118e6925afa51a8b5f2067fcde};
        rv[10] = '{2, 4'd3,  128'ha8b09c1a93d194cdbe49846eb75d5b9a};
        rv[11] = '{2, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e};
        rv[12] = '{2, 4'd15, 128'h0};

        rst = 1'b1; start = 1'b0; key_len = 2'b00; key_in = 256'h0; rk_addr = 4'd0;
        tick(); tick(); tick();
        chk("reset_flags", {124'd0, busy, done, err, rk_valid}, 128'd0);
        chk("reset_rk_data", rk_data, 128'h0);
        chk("reset_num_rounds", 128'(num_rounds), 128'd10);
        rst = 1'b0;
        tick();

        // Table-driven expansions and reads (key 0 carries the stray start pulses).
        for (int k = 0; k < 3; k++) begin
            run_expand(k);
            read_checks(k);
        end

        // Reset mid-expansion, then a fresh AES-192 run.
        key_len = 2'b00; key_in = kv[0].key; start = 1'b1;
        tick();                     // E0
        start = 1'b0;
        for (int c = 0; c < 19; c++) tick();
        rst = 1'b1;
        tick();                     // E0+20
        rst = 1'b0;
        chk("midrst_flags", {124'd0, busy, done, err, rk_valid}, 128'd0);
        chk("midrst_rk_data", rk_data, 128'h0);
        chk("midrst_num_rounds", 128'(num_rounds), 128'd10);
        tick();
        chk("midrst_still_idle", {126'd0, busy, rk_valid}, 128'd0);
        run_expand(1);
        read_checks(1);

        // Reserved key_len: one-cycle err, no busy, store and rk_valid untouched.
        key_len = 2'b11; key_in = kv[2].key; start = 1'b1;
        tick();
        start = 1'b0;
        chk("err_pulse", {125'd0, err, busy, rk_valid}, {125'd0, 3'b101});
        tick();
        chk("err_clear", {125'd0, err, busy, rk_valid}, {125'd0, 3'b001});
        chk("err_keeps_nr", 128'(num_rounds), 128'd12);
        rk_addr = 4'd0;
        tick();
        chk("err_keeps_store", rk_data, 128'h8e73b0f7da0e6452c810f32b809079e5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
